atm_keypad_scanner: RTL and testbench

Matrix-keypad front end for the ATM controller. Scans a 4x4 active-low keypad, synchronises and debounces the column lines, and delivers each debounced key press as a 5-bit code with a one-cycle strobe on the `digito`/`digito_stb` pair consumed by the controller. It sits directly upstream of that controller. It emits exactly one strobe per physical press and has no auto-repeat.

---
 rtl/atm_keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_atm_keypad_scanner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_scanner.sv
// 4x4 active-low keypad scanner: row drive, 2-flop column synchroniser, press/release
// debounce and one strobed 5-bit key code per physical press.
module atm_keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] digito,
  output logic       digito_stb,
  output logic       tecla_activa,
  output logic       multi_key
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [19:0] DEB_TGT  = 20'(DEBOUNCE_CYCLES);

  state_t      state;
  logic [1:0]  row_idx;
  logic [15:0] div;
  logic [19:0] deb_cnt;
  logic [3:0]  col_m;
  logic [3:0]  col_s;
  logic [3:0]  col_pat;
  logic [1:0]  key_row;
  logic [1:0]  key_col;

  logic [19:0] cnt_inc;
  logic        deb_done;
  logic        one_low;
  logic [1:0]  low_col;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'h0: code = 5'd1;   4'h1: code = 5'd2;   4'h2: code = 5'd3;   4'h3: code = 5'd16;
      4'h4: code = 5'd4;   4'h5: code = 5'd5;   4'h6: code = 5'd6;   4'h7: code = 5'd17;
      4'h8: code = 5'd7;   4'h9: code = 5'd8;   4'hA: code = 5'd9;   4'hB: code = 5'd18;
      4'hC: code = 5'd20;  4'hD: code = 5'd0;   4'hE: code = 5'd21;  default: code = 5'd19;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      col_m <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  always_comb begin
    one_low = 1'b1;
    low_col = 2'd0;
    case (col_s)
      4'b1110: low_col = 2'd0;
      4'b1101: low_col = 2'd1;
      4'b1011: low_col = 2'd2;
      4'b0111: low_col = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Saturating increment; "reached" means this cycle's increment hits the target.
  assign cnt_inc  = (deb_cnt == 20'hFFFFF) ? deb_cnt : deb_cnt + 20'd1;
  assign deb_done = (cnt_inc >= DEB_TGT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SCAN;
      row_idx      <= 2'd0;
      div          <= 16'd0;
      deb_cnt      <= 20'd0;
      col_pat      <= 4'b1111;
      key_row      <= 2'd0;
      key_col      <= 2'd0;
      row_out      <= 4'b1111;
      digito       <= 5'd0;
      digito_stb   <= 1'b0;
      tecla_activa <= 1'b0;
      multi_key    <= 1'b0;
    end else begin
      digito_stb <= 1'b0;
      multi_key  <= 1'b0;
      case (state)
        SCAN: begin
          row_out <= row_drive(row_idx);
          if (div == DIV_LAST) begin
            div <= 16'd0;
            if (one_low) begin
              key_row <= row_idx;
              key_col <= low_col;
              col_pat <= col_s;
              deb_cnt <= 20'd0;
              state   <= DEB_PRESS;
            end else begin
              multi_key <= (col_s != 4'b1111);
              row_idx   <= row_idx + 2'd1;
              row_out   <= row_drive(row_idx + 2'd1);
            end
          end else begin
            div <= div + 16'd1;
          end
        end
        DEB_PRESS: begin
          if (col_s == col_pat) begin
            deb_cnt <= cnt_inc;
            if (deb_done) begin
              digito       <= key_code(key_row, key_col);
              digito_stb   <= 1'b1;
              tecla_activa <= 1'b1;
              state        <= PRESSED;
            end
          end else begin
            row_idx <= row_idx + 2'd1;
            row_out <= row_drive(row_idx + 2'd1);
            div     <= 16'd0;
            state   <= SCAN;
          end
        end
        PRESSED: begin
          if (col_s == 4'b1111) begin
            deb_cnt <= 20'd0;
            state   <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (col_s == 4'b1111) begin
            deb_cnt <= cnt_inc;
            if (deb_done) begin
              tecla_activa <= 1'b0;
              row_idx      <= 2'd0;
              row_out      <= 4'b1110;
              div          <= 16'd0;
              state        <= SCAN;
            end
          end else begin
            state <= PRESSED;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_keypad_scanner.sv
// Bench for atm_keypad_scanner: keypad matrix model, strobe scoreboard and scenario tasks.
module tb_atm_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [4:0] digito;
  logic       digito_stb;
  logic       tecla_activa;
  logic       multi_key;

  logic [15:0] keys;    // bit r*4+c = key at (row r, col c) held down
  logic        bounce;  // forces every column open

  logic [4:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int stb_count = 0;
  int multi_cnt = 0;
  int cyc = 0;
  int last_stb_cyc = 0;

  atm_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .digito(digito), .digito_stb(digito_stb), .tecla_activa(tecla_activa),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    col_in = 4'b1111;
    if (!bounce) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end
  end

  // Scoreboard: each strobe pops the next expected code.
  always @(negedge clk) begin
    logic [4:0] exp;
    if (digito_stb) begin
      stb_count++;
      last_stb_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_stb: digito=%0d strobed, none expected", digito);
      end else begin
        exp = exp_q.pop_front();
        if (digito !== exp) begin
          miscompares++;
          $display("FAIL digito_code: got %0d, expected %0d", digito, exp);
        end
      end
    end
    if (multi_key) multi_cnt++;
    if (digito_stb || multi_key) begin
      vectors++;
      if (digito_stb && multi_key) begin
        miscompares++;
        $display("FAIL stb_multi_overlap: both high, expected exclusive");
      end
    end
  end

  task automatic wait_stb(input int start);
    int n = 0;
    while (stb_count == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (stb_count == start) begin
      miscompares++;
      $display("FAIL stb_timeout: no strobe in %0d cycles, expected one", n);
    end
  endtask

  task automatic wait_tecla_low();
    int n = 0;
    while (tecla_activa !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tecla_activa !== 1'b0) begin
      miscompares++;
      $display("FAIL tecla_timeout: tecla_activa=%b after %0d cycles, expected 0", tecla_activa, n);
    end
  endtask

  task automatic wait_row(input logic [3:0] want);
    int n = 0;
    while (row_out !== want && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (row_out !== want) begin
      miscompares++;
      $display("FAIL row_wait: row_out=%b, expected %b", row_out, want);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [3:0] exp_row);
    vectors++;
    if ({row_out, digito, digito_stb, tecla_activa, multi_key} !== {exp_row, 8'h00}) begin
      miscompares++;
      $display("FAIL %s: row=%b dig=%0d stb=%b tec=%b multi=%b, expected row=%b rest 0",
               tag, row_out, digito, digito_stb, tecla_activa, multi_key, exp_row);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [4];
    logic [3:0] cur;
    int n;
    int s0, m0;
    exp_rows[0] = 4'b1101; exp_rows[1] = 4'b1011;
    exp_rows[2] = 4'b0111; exp_rows[3] = 4'b1110;
    reset = 1'b1; keys = '0; bounce = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state", 4'b1111);
    s0 = stb_count; m0 = multi_cnt;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("first_row", 4'b1110);
    n = 0;
    while (row_out == 4'b1110 && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      cur = row_out;
      vectors++;
      if (cur !== exp_rows[i]) begin
        miscompares++;
        $display("FAIL row_seq[%0d]: row_out=%b, expected %b", i, cur, exp_rows[i]);
      end
      n = 0;
      while (row_out == cur && n < 20) begin @(negedge clk); n++; end
      vectors++;
      if (n != 4) begin
        miscompares++;
        $display("FAIL row_dwell[%0d]: %0d cycles, expected 4", i, n);
      end
    end
    vectors++;
    if (stb_count != s0 || multi_cnt != m0 || tecla_activa !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_quiet: stb=%0d multi=%0d tec=%b, expected none", stb_count - s0,
               multi_cnt - m0, tecla_activa);
    end
  endtask

  task automatic test_single_key();
    int s0;
    s0 = stb_count;
    exp_q.push_back(5'd5);
    @(posedge clk); #1 keys[5] = 1'b1;
    repeat (40) @(posedge clk);
    vectors++;
    if (stb_count != s0 + 1 || tecla_activa !== 1'b1 || digito !== 5'd5) begin
      miscompares++;
      $display("FAIL key5_held: strobes=%0d tec=%b dig=%0d, expected 1 1 5", stb_count - s0,
               tecla_activa, digito);
    end
    #1 keys[5] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (tecla_activa !== 1'b1) begin
      miscompares++;
      $display("FAIL release_early: tecla_activa=%b 10 cycles after release, expected 1", tecla_activa);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (tecla_activa !== 1'b0) begin
      miscompares++;
      $display("FAIL release_latency: tecla_activa=%b 11 cycles after release, expected 0", tecla_activa);
    end
    repeat (20) @(posedge clk);
    vectors++;
    if (stb_count != s0 + 1 || digito !== 5'd5) begin
      miscompares++;
      $display("FAIL key5_once: strobes=%0d dig=%0d, expected 1 and 5", stb_count - s0, digito);
    end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = stb_count;
    exp_q.push_back(5'd21);
    @(negedge clk);
    wait_row(4'b1110);
    @(posedge clk); #1 keys[14] = 1'b1;
    @(negedge clk);
    wait_row(4'b0111);
    // Row 3 dwell began at the last edge; its counter reads 5 seven cycles into debounce.
    repeat (7) @(posedge clk);
    #1 bounce = 1'b1;
    @(posedge clk); #1 bounce = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (stb_count != s0) begin
      miscompares++;
      $display("FAIL bounce_abort: %0d strobes from bounced attempt, expected 0", stb_count - s0);
    end
    wait_stb(s0);
    repeat (4) @(posedge clk);
    #1 keys[14] = 1'b0;
    @(negedge clk);
    wait_tecla_low();
    vectors++;
    if (stb_count != s0 + 1) begin
      miscompares++;
      $display("FAIL bounce_once: %0d strobes, expected 1", stb_count - s0);
    end
  endtask

  task automatic test_multi_key();
    int s0, m0;
    @(posedge clk); #1 keys = 16'h0003;
    repeat (4) @(posedge clk);
    s0 = stb_count; m0 = multi_cnt;
    repeat (64) @(posedge clk);
    vectors++;
    if (multi_cnt - m0 != 4 || stb_count != s0) begin
      miscompares++;
      $display("FAIL multi_key: %0d pulses %0d strobes in 4 scans, expected 4 and 0",
               multi_cnt - m0, stb_count - s0);
    end
    #1 keys = '0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [4:0] codes [4];
    int idx [4];
    int s0, prev_cyc;
    codes[0] = 5'd4; codes[1] = 5'd7; codes[2] = 5'd3; codes[3] = 5'd0;
    idx[0] = 4; idx[1] = 8; idx[2] = 2; idx[3] = 13;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      s0 = stb_count;
      exp_q.push_back(codes[i]);
      @(posedge clk); #1 keys[idx[i]] = 1'b1;
      @(negedge clk);
      wait_stb(s0);
      if (i > 0) begin
        vectors++;
        if (last_stb_cyc - prev_cyc < 20) begin
          miscompares++;
          $display("FAIL stb_spacing[%0d]: %0d cycles, expected >= 20", i, last_stb_cyc - prev_cyc);
        end
      end
      prev_cyc = last_stb_cyc;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1 keys[idx[i]] = 1'b0;
      @(negedge clk);
      wait_tecla_low();
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
  endtask

  task automatic test_reset_mid_press();
    int s0;
    s0 = stb_count;
    exp_q.push_back(5'd19);
    @(posedge clk); #1 keys[15] = 1'b1;
    @(negedge clk);
    wait_stb(s0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (tecla_activa !== 1'b1 || digito !== 5'd19) begin
      miscompares++;
      $display("FAIL keyD_pressed: tec=%b dig=%0d, expected 1 and 19", tecla_activa, digito);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("reset_mid_press", 4'b1111);
    s0 = stb_count;
    exp_q.push_back(5'd19);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    wait_stb(s0);
    @(posedge clk); #1 keys[15] = 1'b0;
    @(negedge clk);
    wait_tecla_low();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected strobes never seen, expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; keys = '0; bounce = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_back_to_back();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
